// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default memory map,
// memory access encoding, FSM state codes and a PC alignment helper.
package fetch_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h8002_0000;
  localparam int unsigned MEM_DEPTH_DEF = 1048576;
  localparam logic [1:0]  ACCESS_WORD   = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // Word-align a byte address by clearing its two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, insn} pairs between the memory return
// path and decode. Flush empties the FIFO and wins over a same-cycle push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for pointers and occupancy; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word reads at the PC, captures the data one
// cycle later, queues {pc, insn} for decode and handles redirect and faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] start_pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic [1:0]  imem_access_size,
  output logic        imem_rw,
  output logic        imem_enable,
  output logic        imem_do_branch,
  input  logic [31:0] imem_data,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out,
  output logic        insn_valid,
  output logic        fault,
  output logic        misaligned
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];
  localparam logic [32:0] PC_LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_DEPTH};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         fault_q, fault_d;
  logic         misaligned_q, misaligned_d;

  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;
  logic          pop, branch, push, space, pc_legal, issue, go_fault;
  logic [CW:0]   occupancy;
  logic [32:0]   pc_end;

  // Handshake, space and legality decisions for the current cycle.
  always_comb begin
    insn_valid = (fifo_count != '0);
    pop        = insn_valid && !stall;
    branch     = branch_taken && (state_q == RUN);
    push       = inflight_q && !branch;
    occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    space      = (occupancy < DEPTH_L);
    // 33-bit end address so a PC near the top of the address space cannot wrap into range.
    pc_end     = {1'b0, pc_q} + 33'd4;
    pc_legal   = (pc_q >= BASE_ADDR) && (pc_end <= PC_LIMIT);
    issue      = (state_q == RUN) && !branch && space && pc_legal;
    go_fault   = (state_q == RUN) && !branch && space && !pc_legal;
  end

  // FSM next state, PC update and in-flight tracking.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fault_d       = fault_q;
    misaligned_d  = misaligned_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = align_word(start_pc);
          if (start_pc[1:0] != 2'b00) misaligned_d = 1'b1;
        end
      end
      RUN: begin
        if (branch) begin
          pc_d = align_word(branch_target);
          if (branch_target[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (issue) begin
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 32'd4;
        end else if (go_fault) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      FAULT: begin
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous active-low reset; reset drops any in-flight read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= BASE_ADDR;
      inflight_q   <= 1'b0;
      fault_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      fault_q      <= fault_d;
      misaligned_q <= misaligned_d;
    end
  end

  // PC of the outstanding read; only consulted while inflight_q is set.
  always_ff @(posedge clock) begin
    inflight_pc_q <= inflight_pc_d;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop && !branch),
    .flush (branch),
    .wdata ({inflight_pc_q, imem_data}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign imem_addr        = pc_q;
  assign imem_access_size = ACCESS_WORD;
  assign imem_rw          = 1'b1;
  assign imem_enable      = issue;
  assign imem_do_branch   = branch;
  assign insn_out         = insn_valid ? fifo_head[31:0]  : 32'd0;
  assign pc_out           = insn_valid ? fifo_head[63:32] : 32'd0;
  assign fault            = fault_q;
  assign misaligned       = misaligned_q;

endmodule
